// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side initiator for the combinational ALU.
// It holds a small operand register file, accepts one register-to-register
// command at a time, presents registered operands to the ALU for a settle
// cycle, captures the ALU answer, writes it back to the destination register
// and offers it on a valid/ready result channel.
module alu_op_sequencer #(
  parameter int WIDTH = 6,
  parameter int NREG  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_fxn,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [AW-1:0]    cmd_rd,
  // direct register-file load
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  // debug read port
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  // ALU side
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_fxn,
  input  logic [WIDTH-1:0] alu_ans,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [AW-1:0]    res_rd,
  output logic             res_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ISSUE        = 2'd1,
    CAPTURE_WAIT = 2'd2,
    RESP         = 2'd3
  } state_t;

  state_t state_reg;

  // Flattened view of the register file, one element per generated register.
  logic [WIDTH-1:0] reg_file [NREG];

  // The writeback happens on the edge that leaves CAPTURE_WAIT.
  logic capture;
  assign capture = (state_reg == CAPTURE_WAIT);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] q_reg;

      // One operand register: ALU writeback takes priority over a direct load
      // aimed at the same register on the same edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg <= '0;
        end else if (capture && (res_rd == AW'(gi))) begin
          q_reg <= alu_ans;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          q_reg <= wr_data;
        end
      end

      assign reg_file[gi] = q_reg;
    end
  endgenerate

  assign rd_data = reg_file[rd_addr];

  // Ready only when idle; forced low while reset is held so nothing is
  // handshaken during reset.
  assign cmd_ready = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE);

  // Command sequencing: accept, let the ALU settle one cycle, capture, then
  // hold the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fxn   <= '0;
      res_data  <= '0;
      res_rd    <= '0;
      res_valid <= 1'b0;
      res_zero  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            // Operands are sampled here; a load on this same edge is not seen.
            alu_a     <= reg_file[cmd_ra];
            alu_b     <= reg_file[cmd_rb];
            alu_fxn   <= cmd_fxn;
            res_rd    <= cmd_rd;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= CAPTURE_WAIT;
        end
        CAPTURE_WAIT: begin
          res_data  <= alu_ans;
          res_zero  <= (alu_ans == '0);
          res_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side initiator for the 6-bit combinational ALU. It issues operations to the ALU and collects the results.
- It holds a 4-entry operand register file. It accepts register-to-register commands over a valid/ready handshake, drives the ALU's a/b/fxn inputs from registers, and captures alu_ans.
- Each captured result is written back to the destination register and returned on a valid/ready result channel.
- It sits between the instruction/control logic and the ALU instance.

Parameters:
- WIDTH, 6, operand/result width; must match the ALU data width.
- NREG, 4, register-file depth; address width AW = log2(NREG) = 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_fxn  input  3  ALU function code, passed to the ALU unchanged.
- cmd_ra  input  AW  source register for operand a.
- cmd_rb  input  AW  source register for operand b.
- cmd_rd  input  AW  destination register.
- wr_en  input  1  direct register-file load strobe.
- wr_addr  input  AW  load address.
- wr_data  input  WIDTH  load data.
- rd_addr  input  AW  debug read address.
- rd_data  output  WIDTH  combinational read of reg[rd_addr].
- alu_a  output  WIDTH  registered operand a to the ALU.
- alu_b  output  WIDTH  registered operand b to the ALU.
- alu_fxn  output  3  registered function code to the ALU.
- alu_ans  input  WIDTH  combinational ALU result.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer accepts.
- res_data  output  WIDTH  captured result.
- res_rd  output  AW  destination register of the result.
- res_zero  output  1  res_data == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - State goes to IDLE.
  - All registers reg[0..3] clear to 0.
  - alu_a, alu_b, alu_fxn, res_data, res_rd clear to 0.
  - res_valid = 0, res_zero = 1, busy = 0.
  - cmd_ready is forced to 0 while rst = 1.
- FSM states: IDLE, ISSUE, CAPTURE_WAIT, RESP.
  - IDLE: cmd_ready = 1. On a clock edge with cmd_valid = 1:
    - Latch alu_a <= reg[cmd_ra], alu_b <= reg[cmd_rb], alu_fxn <= cmd_fxn, res_rd <= cmd_rd.
    - Go to ISSUE.
  - ISSUE: ALU inputs are stable for one full cycle. Go to CAPTURE_WAIT. This is the settle cycle for the ALU's ripple paths.
  - CAPTURE_WAIT: at the clock edge:
    - res_data <= alu_ans.
    - reg[res_rd] <= alu_ans.
    - res_valid <= 1.
    - Go to RESP.
  - RESP: hold res_valid, res_data and res_rd stable until res_ready = 1.
    - On the edge with res_ready = 1: res_valid <= 0, go to IDLE.
    - There is no timeout.
- Timing:
  - Latency: command accepted at edge E0, res_valid = 1 after edge E2.
  - Minimum command spacing is 4 cycles (res_ready tied high).
  - cmd_ready is low in ISSUE, CAPTURE_WAIT and RESP. A cmd_valid asserted in those states is ignored and not queued.
- Operand hazards:
  - Operands are sampled at accept.
  - A wr_en to cmd_ra or cmd_rb on the accept edge is not seen by that command; the old value is used.
  - A later wr_en does not change alu_a or alu_b.
- Write collision: if wr_en targets res_rd on the CAPTURE_WAIT edge, the ALU writeback wins and the wr_data is dropped.
- wr_en is honoured in every state, subject to the collision rule.
- Aliasing:
  - ra == rb is legal.
  - rd equal to ra or rb is legal; the write occurs after operands are latched.
- Arithmetic: the sequencer applies no arithmetic. res_data is exactly alu_ans, truncated to WIDTH, with no sign extension or flags beyond res_zero.
- Reset mid-operation: any in-flight command is discarded, res_valid drops immediately, and no writeback occurs.

Test Plan:
- Reset release:
  - During and after rst: cmd_ready = 0 while rst = 1; then cmd_ready = 1 and busy = 0.
  - Stimulus: rd_addr = 0..3. Required: rd_data = 0 for every address.
  - Required: res_valid = 0, res_zero = 1.
- Pass-through:
  - Stimulus: load reg0 = 5, reg1 = 3; command fxn = 0, ra = 0, rb = 1, rd = 2.
  - Required: alu_a = 5, alu_b = 3, alu_fxn = 0 one cycle after accept.
  - Required: res_valid rises 2 edges after accept with res_data = 5, res_rd = 2.
  - Required: rd_addr = 2 returns 5.
- XNOR with back-pressure:
  - Stimulus: reg0 = 5, reg1 = 3, fxn = 5, rd = 3; hold res_ready = 0 for 4 cycles.
  - Required: res_valid and res_data = 57 (6'b111001) remain stable throughout, and cmd_ready = 0 throughout.
  - Required: after res_ready pulses, state returns to IDLE.
- Hazard and collision:
  - Stimulus: wr_en to ra on the accept edge.
  - Required: the old value is used.
  - Stimulus: wr_en with wr_addr = rd on the CAPTURE_WAIT edge.
  - Required: reg[rd] holds alu_ans, not wr_data.
- Negate and zero flag:
  - Stimulus: reg0 = 5, fxn = 2.
  - Required: res_data = 59 (6'b111011), res_zero = 0.
  - Stimulus: reg0 = 0, fxn = 0.
  - Required: res_data = 0, res_zero = 1.
- Async reset in RESP:
  - Stimulus: assert rst mid-cycle while in RESP.
  - Required: res_valid drops before the next clock edge, all registers read 0, and cmd_ready = 1 one cycle after rst deasserts.
